// File: rtl/fp_max_pool.sv
// Streaming IEEE-754 single max-pool over WINDOW products with stb/ack handshakes on both sides.
// Optional macro FP_MAX_POOL_NAN_PROPAGATE_EN: any NaN in a window forces a quiet-NaN result.
module fp_max_pool #(
    parameter int unsigned WINDOW = 4,
    parameter int unsigned IDX_W  = $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      input_z,
    input  logic             input_z_stb,
    output logic             input_z_ack,
    output logic [31:0]      output_m,
    output logic [IDX_W-1:0] output_m_idx,
    output logic             output_m_stb,
    input  logic             output_m_ack
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {StGet, StCmp, StPut} state_e;

    function automatic logic f_is_nan(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

    // Strict greater-than; +0 and -0 compare equal so the earlier sample wins.
    function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) begin
            return !a[31] && ((a[30:0] != 31'd0) || (b[30:0] != 31'd0));
        end else if (!a[31]) begin
            return a[30:0] > b[30:0];
        end else begin
            return a[30:0] < b[30:0];
        end
    endfunction

    state_e           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_count, w_count_nxt;
    logic [31:0]      r_cand, w_cand_nxt;
    logic [31:0]      r_max, w_max_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_ack, w_ack_nxt;
    logic [31:0]      r_out_m, w_out_m_nxt;
    logic [IDX_W-1:0] r_out_idx, w_out_idx_nxt;
    logic             r_out_stb, w_out_stb_nxt;

    logic             w_first;
    logic             w_cand_nan;
    logic             w_replace;
    logic [31:0]      w_max_upd;
    logic [IDX_W-1:0] w_idx_upd;
    logic [31:0]      w_result;
    logic [IDX_W-1:0] w_res_idx;

    assign w_first    = (r_count == '0);
    assign w_cand_nan = f_is_nan(r_cand);
    // A NaN max only exists while every sample so far was NaN; any number displaces it.
    assign w_replace  = w_first || (!w_cand_nan && (f_is_nan(r_max) || f_gt(r_cand, r_max)));
    assign w_max_upd  = w_replace ? r_cand : r_max;
    assign w_idx_upd  = w_replace ? r_count : r_idx;

`ifdef FP_MAX_POOL_NAN_PROPAGATE_EN
    logic             r_nan, w_nan_nxt;
    logic [IDX_W-1:0] r_nan_idx, w_nan_idx_nxt;
    logic             w_nan_prev;
    logic             w_nan_upd;
    logic [IDX_W-1:0] w_nan_idx_upd;

    assign w_nan_prev    = w_first ? 1'b0 : r_nan;
    assign w_nan_upd     = w_nan_prev | w_cand_nan;
    assign w_nan_idx_upd = (w_cand_nan && !w_nan_prev) ? r_count : r_nan_idx;
    assign w_result      = w_nan_upd ? QNAN : w_max_upd;
    assign w_res_idx     = w_nan_upd ? w_nan_idx_upd : w_idx_upd;
`else
    assign w_result  = f_is_nan(w_max_upd) ? QNAN : w_max_upd;
    assign w_res_idx = w_idx_upd;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_cand_nxt    = r_cand;
        w_max_nxt     = r_max;
        w_idx_nxt     = r_idx;
        w_ack_nxt     = r_ack;
        w_out_m_nxt   = r_out_m;
        w_out_idx_nxt = r_out_idx;
        w_out_stb_nxt = r_out_stb;
`ifdef FP_MAX_POOL_NAN_PROPAGATE_EN
        w_nan_nxt     = r_nan;
        w_nan_idx_nxt = r_nan_idx;
`endif
        unique case (r_state)
            StGet: begin
                w_ack_nxt = 1'b1;
                if (input_z_stb && r_ack) begin
                    w_cand_nxt  = input_z;
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = StCmp;
                end
            end
            StCmp: begin
                w_max_nxt = w_max_upd;
                w_idx_nxt = w_idx_upd;
`ifdef FP_MAX_POOL_NAN_PROPAGATE_EN
                w_nan_nxt     = w_nan_upd;
                w_nan_idx_nxt = w_nan_idx_upd;
`endif
                if (r_count == IDX_W'(WINDOW - 1)) begin
                    w_out_m_nxt   = w_result;
                    w_out_idx_nxt = w_res_idx;
                    w_out_stb_nxt = 1'b1;
                    w_state_nxt   = StPut;
                end else begin
                    // Re-arm ack here so the next product lands two cycles after the last.
                    w_count_nxt = r_count + 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = StGet;
                end
            end
            StPut: begin
                w_ack_nxt = 1'b0;
                if (output_m_ack) begin
                    w_out_stb_nxt = 1'b0;
                    w_count_nxt   = '0;
                    w_ack_nxt     = 1'b1;
                    w_state_nxt   = StGet;
`ifdef FP_MAX_POOL_NAN_PROPAGATE_EN
                    w_nan_nxt     = 1'b0;
`endif
                end
            end
            default: w_state_nxt = StGet;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StGet;
            r_count   <= '0;
            r_cand    <= '0;
            r_max     <= '0;
            r_idx     <= '0;
            r_ack     <= 1'b0;
            r_out_m   <= '0;
            r_out_idx <= '0;
            r_out_stb <= 1'b0;
`ifdef FP_MAX_POOL_NAN_PROPAGATE_EN
            r_nan     <= 1'b0;
            r_nan_idx <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_cand    <= w_cand_nxt;
            r_max     <= w_max_nxt;
            r_idx     <= w_idx_nxt;
            r_ack     <= w_ack_nxt;
            r_out_m   <= w_out_m_nxt;
            r_out_idx <= w_out_idx_nxt;
            r_out_stb <= w_out_stb_nxt;
`ifdef FP_MAX_POOL_NAN_PROPAGATE_EN
            r_nan     <= w_nan_nxt;
            r_nan_idx <= w_nan_idx_nxt;
`endif
        end
    end

    assign input_z_ack  = r_ack;
    assign output_m     = r_out_m;
    assign output_m_idx = r_out_idx;
    assign output_m_stb = r_out_stb;

endmodule

// File: tb/tb_fp_max_pool.sv
// Directed, table-driven bench for fp_max_pool (WINDOW=4) plus backpressure and reset sequences.
module tb_fp_max_pool;

    localparam int unsigned WINDOW = 4;
    localparam int unsigned IDX_W  = 2;

    logic             clk;
    logic             rst;
    logic [31:0]      input_z;
    logic             input_z_stb;
    logic             input_z_ack;
    logic [31:0]      output_m;
    logic [IDX_W-1:0] output_m_idx;
    logic             output_m_stb;
    logic             output_m_ack;

    int checks = 0;
    int errors = 0;

    fp_max_pool #(.WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .input_z     (input_z),
        .input_z_stb (input_z_stb),
        .input_z_ack (input_z_ack),
        .output_m    (output_m),
        .output_m_idx(output_m_idx),
        .output_m_stb(output_m_stb),
        .output_m_ack(output_m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string           name;
        logic [3:0][31:0] z;
        logic [31:0]     m;
        logic [1:0]      idx;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input logic [31:0] m, input logic [1:0] idx);
        vec_t v;
        v.name = n;
        v.z    = {d, c, b, a};
        v.m    = m;
        v.idx  = idx;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    // Drive one product; returns #1 after the edge on which it transferred.
    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        input_z     = d;
        input_z_stb = 1'b1;
        while (!input_z_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ack=0 for 50 cycles, required ack=1");
        end
        @(posedge clk);
        #1;
        input_z_stb = 1'b0;
    endtask

    // Full window with output_m_ack held high: result must be visible after the edge following
    // the final transfer and be accepted on the next edge.
    task automatic run_window(input vec_t v);
        for (int i = 0; i < 4; i++) send(v.z[i]);
        check({v.name, " stb_early"}, 32'(output_m_stb), 32'd0);
        @(posedge clk);
        #1;
        check({v.name, " stb_rise"}, 32'(output_m_stb), 32'd1);
        check({v.name, " m"}, output_m, v.m);
        check({v.name, " idx"}, 32'(output_m_idx), 32'(v.idx));
        @(posedge clk);
        #1;
        check({v.name, " stb_fall"}, 32'(output_m_stb), 32'd0);
        check({v.name, " ack_rearm"}, 32'(input_z_ack), 32'd1);
    endtask

    initial begin
        vecs[0] = mk("basic", 32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40000000,
                     32'h40400000, 2'd2);
        vecs[1] = mk("all_neg", 32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0E08312,
                     32'hBF800000, 2'd0);
        vecs[2] = mk("signed_zero", 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000,
                     32'h80000000, 2'd0);
        vecs[3] = mk("tie", 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
                     32'h40000000, 2'd0);
`ifdef FP_MAX_POOL_NAN_PROPAGATE_EN
        vecs[4] = mk("nan_mid", 32'h3F800000, 32'h7FC00000, 32'h40400000, 32'h40000000,
                     32'h7FC00000, 2'd1);
        vecs[5] = mk("nan_first", 32'h7FC00000, 32'hBF800000, 32'h3F800000, 32'h40000000,
                     32'h7FC00000, 2'd0);
`else
        vecs[4] = mk("nan_mid", 32'h3F800000, 32'h7FC00000, 32'h40400000, 32'h40000000,
                     32'h40400000, 2'd2);
        vecs[5] = mk("nan_first", 32'h7FC00000, 32'hBF800000, 32'h3F800000, 32'h40000000,
                     32'h40000000, 2'd3);
`endif
        vecs[6] = mk("all_nan", 32'h7F800001, 32'hFFC00000, 32'h7FC00000, 32'h7FFFFFFF,
                     32'h7FC00000, 2'd0);
        vecs[7] = mk("inf", 32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'h00000001,
                     32'h7F800000, 2'd0);
        vecs[8] = mk("denorm", 32'h00000001, 32'h00000002, 32'h80000005, 32'h00000000,
                     32'h00000002, 2'd1);
        vecs[9] = mk("neg_inf_last", 32'hC0000000, 32'hFF800000, 32'hC1000000, 32'h7F800000,
                     32'h7F800000, 2'd3);

        input_z      = '0;
        input_z_stb  = 1'b0;
        output_m_ack = 1'b1;
        rst          = 1'b1;
        #1;
        rst = 1'b0;
        #12;
        check("reset ack", 32'(input_z_ack), 32'd0);
        check("reset m", output_m, 32'd0);
        check("reset idx", 32'(output_m_idx), 32'd0);
        check("reset stb", 32'(output_m_stb), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ack_after_reset", 32'(input_z_ack), 32'd1);

        for (int i = 0; i < 10; i++) run_window(vecs[i]);

        // Backpressure: result held 10 cycles, strobes on input ignored.
        output_m_ack = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[0].z[i]);
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            check("bp stb", 32'(output_m_stb), 32'd1);
            check("bp m", output_m, 32'h40400000);
            check("bp idx", 32'(output_m_idx), 32'd2);
            check("bp ack", 32'(input_z_ack), 32'd0);
            input_z     = 32'h7F000000;
            input_z_stb = c[0];
            @(posedge clk);
            #1;
        end
        input_z_stb  = 1'b0;
        output_m_ack = 1'b1;
        @(posedge clk);
        #1;
        check("bp release stb", 32'(output_m_stb), 32'd0);
        run_window(vecs[1]);

        // Reset mid-window: partial window discarded.
        send(32'h7F000000);
        send(32'h3F800000);
        rst = 1'b0;
        #1;
        check("midrst ack", 32'(input_z_ack), 32'd0);
        check("midrst m", output_m, 32'd0);
        check("midrst idx", 32'(output_m_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_window(mk("post_reset", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                      32'h40000000, 2'd3));

        // Reset mid-PUT: pending result dropped.
        output_m_ack = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[7].z[i]);
        @(posedge clk);
        #1;
        check("put stb", 32'(output_m_stb), 32'd1);
        rst = 1'b0;
        #1;
        check("putrst stb", 32'(output_m_stb), 32'd0);
        check("putrst m", output_m, 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        output_m_ack = 1'b1;
        run_window(vecs[8]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
